issue_wb_arbiter: RTL and testbench
===================================

# issue_wb_arbiter

Shares the single writeback wake-up bus of the issue stage (`wb_en` / `wb_dst_rob` / `wb_value` / `wb_lsmiss`) between the four execution pipes: ALU, MUL, MEM and BRU. Each pipe pushes completed results through a valid/ready handshake into a private FIFO. A round-robin arbiter pops one result per cycle onto a registered writeback bus, which feeds the issue stage's wake-up inputs. `snoop_hit` flushes all buffered, not-yet-written-back results.

## Interface
- `BUF_DEPTH`, default 2, per-source FIFO depth; legal values 2 or 4.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `snoop_hit`  in  1  pipeline flush, sampled on clk.
- `src_valid`  in  4  per-source result valid; bit 0 ALU, 1 MUL, 2 MEM, 3 BRU.
- `src_ready`  out  4  per-source FIFO can accept.
- `src_dst_rob`  in  16  4 bits per source, source i at [4i+3:4i].
- `src_value`  in  128  32 bits per source, source i at [32i+31:32i].
- `src_lsmiss`  in  4  per-source load/store-miss flag; only MEM drives it nonzero in practice.
- `wb_en`  out  1  writeback valid, registered.
- `wb_dst_rob`  out  4  writeback ROB index, registered.
- `wb_value`  out  32  writeback value, registered.
- `wb_lsmiss`  out  1  writeback lsmiss flag, registered.
- `wb_grant`  out  4  one-hot source of the current writeback; 0 when `wb_en`=0.
- `busy`  out  1  any FIFO non-empty or `wb_en`=1.

## Operation
- **Per-source FIFO.** Each of the four sources has a circular FIFO of `BUF_DEPTH` entries holding {dst_rob, value, lsmiss}.
  - State: read pointer, write pointer (log2(`BUF_DEPTH`) bits, natural wrap) and count (0..`BUF_DEPTH`).
- **Ready.** `src_ready[i]` = (count_i != `BUF_DEPTH`).
  - It is computed from the registered count only and never depends on `src_valid` or on a same-cycle pop.
  - A full FIFO therefore shows ready=0 even in a cycle where it is popped.
- **Push.** `src_valid[i]` & `src_ready[i]` pushes at the edge.
- **Arbitration.** A 2-bit `rr_ptr` selects priority order `rr_ptr`, `rr_ptr`+1, ... mod 4.
  - The first source with count != 0 is granted and popped.
  - On a grant to source k, `rr_ptr` ← (k+1) mod 4. With no grant, `rr_ptr` holds.
- **Writeback register.** Updated at every edge:
  - With a grant: `wb_en`=1; `wb_dst_rob`/`wb_value`/`wb_lsmiss` = popped entry; `wb_grant`=1<<k.
  - Without a grant: `wb_en`=0 and `wb_grant`=0; data fields hold their last value.
- **lsmiss entries** are arbitrated like any other. The issue stage masks them.
- **Simultaneous push and pop** on the same FIFO: count unchanged, both pointers advance.
- **Flush.** When `snoop_hit`=1 at an edge, regardless of other inputs:
  - all counts and pointers ← 0;
  - that cycle's pushes are discarded;
  - that cycle's grant is discarded, giving `wb_en`=0 and `wb_grant`=0 next cycle;
  - `rr_ptr` ← 0.
- **Reset values** (while `resetn`=0): counts, pointers and `rr_ptr` = 0; `wb_en`=0, `wb_dst_rob`=0, `wb_value`=0, `wb_lsmiss`=0, `wb_grant`=0; `src_ready`=4'b1111; `busy`=0.
- **Reset mid-operation** discards all buffered entries and the in-flight writeback immediately (asynchronous).

## Timing
- **Minimum latency** is 2 cycles:
  - push at edge N;
  - entry visible to the arbiter in cycle N..N+1;
  - popped at edge N+1;
  - `wb_en`=1 during cycle N+1..N+2.
- **Throughput:** one writeback per cycle aggregate. Each source is guaranteed at least one grant in any 4 consecutive cycles while non-empty.
- **Backpressure:** a source pushing every cycle while losing arbitration sees ready fall the cycle after its FIFO fills. Ready reasserts the cycle after the first pop.
- **Handshake:** sources must hold `src_valid` and data until ready=1. A source must not drop a valid result except on `snoop_hit`.
- **`busy`** is combinational from registered state only.

## Test plan
- **Single push.** Reset, then ALU pushes rob=3, value=0x12345678 at edge 1.
  - Expect `wb_en`=1, `wb_dst_rob`=3, `wb_value`=0x12345678, `wb_grant`=4'b0001 after edge 2.
  - Expect `wb_en`=0 after edge 3.
- **Round-robin order.** All four sources push one result at the same edge (rob 0,1,2,3).
  - Writebacks appear on 4 consecutive cycles with `wb_grant` 0001, 0010, 0100, 1000.
  - Next push from MEM alone: grant 0100 and `rr_ptr`=3 after.
- **Backpressure and wrap-around.** `BUF_DEPTH`=2; MUL and BRU push continuously for 10 cycles with incrementing rob.
  - MUL ready toggles as the FIFO fills and drains.
  - No rob lost or duplicated.
  - Per-source order preserved across pointer wrap.
  - Grants alternate MUL/BRU.
- **lsmiss passthrough.** MEM pushes rob=9, lsmiss=1.
  - Expect `wb_en`=1, `wb_lsmiss`=1, `wb_grant`=4'b0100.
- **Flush.** Fill ALU and MEM FIFOs, then assert `snoop_hit` in a cycle with a pending grant and a push.
  - Next cycle: `wb_en`=0, `busy`=0, `src_ready`=4'b1111.
  - No writeback of any pre-flush entry thereafter.
- **Reset mid-operation.** Deassert `resetn` asynchronously mid-cycle with 3 entries buffered.
  - Outputs go to their reset values immediately.
  - After release, the first new push writes back with 2-cycle latency and grant order restarts at ALU.

Source files
------------

// File: rtl/issue_wb_arbiter.sv
// Shares the issue-stage writeback wake-up bus between the ALU, MUL, MEM and BRU pipes:
// per-pipe result FIFOs feed a round-robin arbiter that drives a registered writeback bus.
module issue_wb_arbiter #(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         snoop_hit,
  input  logic [3:0]   src_valid,
  output logic [3:0]   src_ready,
  input  logic [15:0]  src_dst_rob,
  input  logic [127:0] src_value,
  input  logic [3:0]   src_lsmiss,
  output logic         wb_en,
  output logic [3:0]   wb_dst_rob,
  output logic [31:0]  wb_value,
  output logic         wb_lsmiss,
  output logic [3:0]   wb_grant,
  output logic         busy
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BUF_DEPTH);

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] value;
    logic        lsmiss;
  } entry_t;

  entry_t          mem_q    [4][BUF_DEPTH];
  logic [PtrW-1:0] rd_ptr_q [4];
  logic [PtrW-1:0] rd_ptr_d [4];
  logic [PtrW-1:0] wr_ptr_q [4];
  logic [PtrW-1:0] wr_ptr_d [4];
  logic [CntW-1:0] cnt_q    [4];
  logic [CntW-1:0] cnt_d    [4];
  logic [1:0]      rr_ptr_q;
  logic [1:0]      rr_ptr_d;

  logic [3:0] nonempty;
  logic [3:0] push;
  logic [3:0] pop;
  logic       grant_any;
  logic [1:0] grant_idx;
  entry_t     pop_entry;

  // Ready comes from the registered count only, so a full FIFO stays not-ready while popped.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nonempty[i]  = (cnt_q[i] != '0);
      src_ready[i] = (cnt_q[i] != CntFull);
      push[i]      = src_valid[i] & src_ready[i] & ~snoop_hit;
    end
  end

  always_comb begin : arb
    logic [1:0] idx;
    idx       = '0;
    grant_any = 1'b0;
    grant_idx = rr_ptr_q;
    for (int j = 0; j < 4; j++) begin
      idx = rr_ptr_q + 2'(j);
      if (!grant_any && nonempty[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    for (int i = 0; i < 4; i++) begin
      pop[i] = grant_any & (grant_idx == 2'(i)) & ~snoop_hit;
    end
    pop_entry = mem_q[grant_idx][rd_ptr_q[grant_idx]];
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (snoop_hit) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(1);
        if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(1);
        if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CntW'(1);
        else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - CntW'(1);
      end
    end
    if (snoop_hit)      rr_ptr_d = '0;
    else if (grant_any) rr_ptr_d = grant_idx + 2'd1;
    else                rr_ptr_d = rr_ptr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q   <= '0;
      wb_en      <= 1'b0;
      wb_dst_rob <= '0;
      wb_value   <= '0;
      wb_lsmiss  <= 1'b0;
      wb_grant   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      if (grant_any && !snoop_hit) begin
        wb_en      <= 1'b1;
        wb_dst_rob <= pop_entry.rob;
        wb_value   <= pop_entry.value;
        wb_lsmiss  <= pop_entry.lsmiss;
        wb_grant   <= 4'b0001 << grant_idx;
      end else begin
        wb_en    <= 1'b0;
        wb_grant <= '0;
      end
    end
  end

  // Payload storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {src_dst_rob[4*i +: 4], src_value[32*i +: 32], src_lsmiss[i]};
      end
    end
  end

  assign busy = (|nonempty) | wb_en;

endmodule

// File: tb/tb_issue_wb_arbiter.sv
// Directed bench for issue_wb_arbiter: per-source scoreboard queues filled on accepted
// pushes and drained against every writeback, plus directed grant/timing checks.
module tb_issue_wb_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         snoop_hit;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [15:0]  src_dst_rob;
  logic [127:0] src_value;
  logic [3:0]   src_lsmiss;
  logic         wb_en;
  logic [3:0]   wb_dst_rob;
  logic [31:0]  wb_value;
  logic         wb_lsmiss;
  logic [3:0]   wb_grant;
  logic         busy;

  always #5 clk = ~clk;

  issue_wb_arbiter #(.BUF_DEPTH(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .snoop_hit  (snoop_hit),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_dst_rob(src_dst_rob),
    .src_value  (src_value),
    .src_lsmiss (src_lsmiss),
    .wb_en      (wb_en),
    .wb_dst_rob (wb_dst_rob),
    .wb_value   (wb_value),
    .wb_lsmiss  (wb_lsmiss),
    .wb_grant   (wb_grant),
    .busy       (busy)
  );

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] value;
    logic        lsmiss;
  } exp_t;

  exp_t       sbq [4][$];
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;
  int         wb_seen = 0;
  int         same_grant = 0;
  logic       track_alt = 1'b0;
  logic       prev_en = 1'b0;
  logic [3:0] prev_grant = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [3:0] rob, input logic [31:0] val,
                         input logic ls);
    src_dst_rob[4*i +: 4]  = rob;
    src_value[32*i +: 32]  = val;
    src_lsmiss[i]          = ls;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 4; i++) sbq[i].delete();
  endtask

  // Records accepted pushes, advances one edge, then scores any writeback.
  task automatic tick();
    exp_t e;
    int   k;
    if (resetn) begin
      if (snoop_hit) clear_sb();
      else begin
        for (int i = 0; i < 4; i++) begin
          if (src_valid[i] && src_ready[i]) begin
            e.rob    = src_dst_rob[4*i +: 4];
            e.value  = src_value[32*i +: 32];
            e.lsmiss = src_lsmiss[i];
            sbq[i].push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (wb_en === 1'b1) begin
      wb_seen++;
      chk("wb_grant_onehot", 32'($onehot(wb_grant)), 1);
      k = 0;
      for (int i = 0; i < 4; i++) if (wb_grant[i]) k = i;
      chk("wb_expected", 32'(sbq[k].size() != 0), 1);
      if (sbq[k].size() != 0) begin
        e = sbq[k].pop_front();
        chk("wb_rob", 32'(wb_dst_rob), 32'(e.rob));
        chk("wb_value", wb_value, e.value);
        chk("wb_lsmiss", 32'(wb_lsmiss), 32'(e.lsmiss));
      end
      if (track_alt && prev_en && (wb_grant == prev_grant)) same_grant++;
    end
    prev_en    = wb_en;
    prev_grant = wb_grant;
  endtask

  task automatic rst_checks();
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_wb_grant", 32'(wb_grant), 0);
    chk("rst_wb_rob", 32'(wb_dst_rob), 0);
    chk("rst_wb_value", wb_value, 0);
    chk("rst_wb_lsmiss", 32'(wb_lsmiss), 0);
    chk("rst_src_ready", 32'(src_ready), 32'hf);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Called 1 time unit after an edge; asserts reset mid-cycle and releases before the next edge.
  task automatic do_reset();
    src_valid = '0;
    snoop_hit = 1'b0;
    #3;
    resetn = 1'b0;
    clear_sb();
    prev_en = 1'b0;
    #1;
    rst_checks();
    #4;
    resetn = 1'b1;
  endtask

  int   wb_mark;
  int   mul_seq;
  int   bru_seq;
  int   mul_trans;
  logic prev_rdy;
  logic acc_mul;
  logic acc_bru;

  initial begin
    resetn      = 1'b0;
    snoop_hit   = 1'b0;
    src_valid   = '0;
    src_dst_rob = '0;
    src_value   = '0;
    src_lsmiss  = '0;
    #12;
    rst_checks();
    #1;
    resetn = 1'b1;

    // Single push with 2-cycle latency
    set_src(0, 4'd3, 32'h1234_5678, 1'b0);
    src_valid = 4'b0001;
    tick();
    src_valid = '0;
    chk("t1_latency_wb_en", 32'(wb_en), 0);
    tick();
    chk("t1_wb_en", 32'(wb_en), 1);
    chk("t1_wb_rob", 32'(wb_dst_rob), 3);
    chk("t1_wb_value", wb_value, 32'h1234_5678);
    chk("t1_wb_grant", 32'(wb_grant), 32'b0001);
    tick();
    chk("t1_wb_en_after", 32'(wb_en), 0);

    // Round-robin from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 4'(i), 32'hA000_0000 + 32'(i), 1'b0);
    src_valid = 4'b1111;
    tick();
    src_valid = '0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("rr_wb_en", 32'(wb_en), 1);
      chk("rr_grant", 32'(wb_grant), 32'd1 << j);
    end
    tick();
    chk("rr_idle", 32'(wb_en), 0);
    set_src(2, 4'd5, 32'h0000_0505, 1'b0);
    src_valid = 4'b0100;
    tick();
    src_valid = '0;
    tick();
    chk("rr_mem_grant", 32'(wb_grant), 32'b0100);
    chk("rr_ptr_after_mem", 32'(dut.rr_ptr_q), 3);

    // lsmiss passthrough
    set_src(2, 4'd9, 32'hDEAD_BEEF, 1'b1);
    src_valid = 4'b0100;
    tick();
    src_valid = '0;
    set_src(2, 4'd0, 32'h0, 1'b0);
    tick();
    chk("ls_wb_en", 32'(wb_en), 1);
    chk("ls_wb_lsmiss", 32'(wb_lsmiss), 1);
    chk("ls_wb_grant", 32'(wb_grant), 32'b0100);
    tick();

    // Backpressure and pointer wrap: MUL and BRU push every cycle
    mul_seq   = 0;
    bru_seq   = 0;
    mul_trans = 0;
    wb_mark   = wb_seen;
    track_alt = 1'b1;
    prev_rdy  = src_ready[1];
    for (int c = 0; c < 10; c++) begin
      set_src(1, 4'(mul_seq), 32'h1000_0000 | 32'(mul_seq), 1'b0);
      set_src(3, 4'(bru_seq + 8), 32'h3000_0000 | 32'(bru_seq), 1'b0);
      src_valid = 4'b1010;
      acc_mul   = src_ready[1];
      acc_bru   = src_ready[3];
      tick();
      if (acc_mul) mul_seq++;
      if (acc_bru) bru_seq++;
      if (src_ready[1] !== prev_rdy) mul_trans++;
      prev_rdy = src_ready[1];
    end
    src_valid = '0;
    track_alt = 1'b0;
    chk("bp_mul_ready_toggles", 32'(mul_trans >= 2), 1);
    chk("bp_grants_alternate", same_grant, 0);
    repeat (6) tick();
    chk("bp_mul_drained", sbq[1].size(), 0);
    chk("bp_bru_drained", sbq[3].size(), 0);
    chk("bp_wb_count", wb_seen - wb_mark, mul_seq + bru_seq);

    // Flush with a pending grant and a push in the flush cycle
    set_src(0, 4'h1, 32'hF100_0001, 1'b0);
    set_src(2, 4'h2, 32'hF200_0002, 1'b0);
    src_valid = 4'b0101;
    tick();
    set_src(0, 4'h3, 32'hF100_0003, 1'b0);
    set_src(2, 4'h4, 32'hF200_0004, 1'b0);
    tick();
    chk("fl_busy_before", 32'(busy), 1);
    set_src(0, 4'h5, 32'hF100_0005, 1'b0);
    set_src(2, 4'h6, 32'hF200_0006, 1'b0);
    snoop_hit = 1'b1;
    tick();
    snoop_hit = 1'b0;
    src_valid = '0;
    chk("fl_wb_en", 32'(wb_en), 0);
    chk("fl_wb_grant", 32'(wb_grant), 0);
    chk("fl_busy", 32'(busy), 0);
    chk("fl_src_ready", 32'(src_ready), 32'hf);
    chk("fl_rr_ptr", 32'(dut.rr_ptr_q), 0);
    wb_mark = wb_seen;
    repeat (4) tick();
    chk("fl_no_stale_wb", wb_seen - wb_mark, 0);

    // Asynchronous reset with 3 entries buffered and a writeback in flight
    for (int i = 0; i < 4; i++) set_src(i, 4'(8 + i), 32'hC000_0000 + 32'(i), 1'b0);
    src_valid = 4'b1111;
    tick();
    src_valid = '0;
    tick();
    chk("mr_wb_en_before", 32'(wb_en), 1);
    chk("mr_busy_before", 32'(busy), 1);
    do_reset();
    set_src(0, 4'hA, 32'h5555_0000, 1'b0);
    set_src(2, 4'hB, 32'h5555_0002, 1'b0);
    src_valid = 4'b0101;
    tick();
    src_valid = '0;
    chk("mr_latency_wb_en", 32'(wb_en), 0);
    tick();
    chk("mr_first_wb_en", 32'(wb_en), 1);
    chk("mr_first_grant", 32'(wb_grant), 32'b0001);
    tick();
    chk("mr_second_grant", 32'(wb_grant), 32'b0100);
    tick();
    chk("mr_idle", 32'(wb_en), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
